// File: rtl/hack_alu_seq.sv
// Multi-cycle, handshaked Hack ALU with shift and shift-add multiply modes.
// Operands are preprocessed (zx/nx/zy/ny) at accept. Single-cycle modes
// register their result directly. Multiply iterates D_WIDTH times before
// presenting the result.
module hack_alu_seq #(
  parameter int unsigned D_WIDTH  = 16,
  parameter int unsigned SH_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] x,
  input  logic [D_WIDTH-1:0] y,
  input  logic               zx,
  input  logic               nx,
  input  logic               zy,
  input  logic               ny,
  input  logic               f,
  input  logic               no,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out,
  output logic               zr,
  output logic               ng
);

  localparam int unsigned CNT_W = $clog2(D_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] out_q, out_d;
  logic [D_WIDTH-1:0] acc_q, acc_d;
  logic [D_WIDTH-1:0] a_q, a_d;
  logic [D_WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               no_q, no_d;

  logic [D_WIDTH-1:0]  vx, vy;
  logic [SH_WIDTH-1:0] amt;
  logic                sh_big;
  logic [D_WIDTH-1:0]  r_hack, r_shl, r_sar, r_single;
  logic [D_WIDTH-1:0]  acc_step;

  // Operand preprocessing and single-cycle function results.
  always_comb begin
    vx = zx ? '0 : x;
    if (nx) vx = ~vx;
    vy = zy ? '0 : y;
    if (ny) vy = ~vy;
    amt    = vy[SH_WIDTH-1:0];
    sh_big = (32'(amt) >= 32'(D_WIDTH));
    r_hack = f ? (vx + vy) : (vx & vy);
    r_shl  = sh_big ? '0 : (vx << amt);
    r_sar  = sh_big ? {D_WIDTH{vx[D_WIDTH-1]}} : D_WIDTH'($signed(vx) >>> amt);
    case (mode)
      2'b01:   r_single = r_shl;
      2'b10:   r_single = r_sar;
      default: r_single = r_hack;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      no_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      no_q    <= no_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    no_d     = no_q;
    acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (mode == 2'b11) begin
            acc_d   = '0;
            a_d     = vx;
            b_d     = vy;
            cnt_d   = '0;
            no_d    = no;
            state_d = S_MUL;
          end else begin
            out_d   = no ? ~r_single : r_single;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_step;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // Final iteration writes the freshly accumulated value straight to out.
        if (cnt_q == CNT_W'(D_WIDTH - 1)) begin
          out_d   = no_q ? ~acc_step : acc_step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and result outputs.
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !reset;
    out_valid = (state_q == S_DONE);
    out       = out_q;
    zr        = (out_q == '0);
    ng        = out_q[D_WIDTH-1];
  end

endmodule

// File: tb/tb_hack_alu_seq.sv
// Self-checking bench for hack_alu_seq: directed plan steps plus randomized
// operations checked against an arithmetic reference model.
module tb_hack_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic [5:0]  ctl;
  logic        zx, nx, zy, ny, f, no;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr, ng;

  int checks = 0;
  int errors = 0;

  assign {zx, nx, zy, ny, f, no} = ctl;

  hack_alu_seq #(.D_WIDTH(16), .SH_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: control bits ordered {zx,nx,zy,ny,f,no}.
  function automatic logic [15:0] model(input logic [15:0] xi, input logic [15:0] yi,
                                        input logic [5:0] c, input logic [1:0] m);
    logic [15:0] vx, vy, r;
    int          sh;
    longint      s;
    vx = c[5] ? 16'h0000 : xi;
    if (c[4]) vx = ~vx;
    vy = c[3] ? 16'h0000 : yi;
    if (c[2]) vy = ~vy;
    sh = int'(vy) % 16;
    case (m)
      2'b00: r = c[1] ? 16'(vx + vy) : (vx & vy);
      2'b01: r = 16'(longint'(vx) * (longint'(1) << sh));
      2'b10: begin
        s = longint'($signed(vx));
        r = 16'(s >>> sh);
      end
      default: r = 16'(longint'(vx) * longint'(vy));
    endcase
    return c[0] ? ~r : r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input string tag, input logic [15:0] xi, input logic [15:0] yi,
                        input logic [5:0] c, input logic [1:0] m,
                        input logic [15:0] exp, input int hold);
    int lat;
    int exp_lat;
    exp_lat = (m == 2'b11) ? 17 : 1;
    check1({tag, "_ready_before"}, in_ready, 1'b1);
    x = xi; y = yi; ctl = c; mode = m;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); ctl = 6'($urandom); mode = 2'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      check1({tag, "_busy_ready"}, in_ready, 1'b0);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check_int({tag, "_latency"}, lat, exp_lat);
    check16({tag, "_out"}, out, exp);
    check1({tag, "_zr"}, zr, exp == 16'h0000);
    check1({tag, "_ng"}, ng, exp[15]);
    check1({tag, "_done_ready"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check1({tag, "_hold_valid"}, out_valid, 1'b1);
      check16({tag, "_hold_out"}, out, exp);
      check1({tag, "_hold_zr"}, zr, exp == 16'h0000);
      check1({tag, "_hold_ng"}, ng, exp[15]);
      check1({tag, "_hold_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check1({tag, "_valid_drop"}, out_valid, 1'b0);
    check1({tag, "_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [15:0] rx, ry;
    logic [5:0]  rc;
    logic [1:0]  rm;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; ctl = '0; mode = '0;
    repeat (2) @(negedge clk);
    check16("reset_out", out, 16'h0000);
    check1("reset_zr", zr, 1'b1);
    check1("reset_ng", ng, 1'b0);
    check1("reset_valid", out_valid, 1'b0);
    check1("reset_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check1("post_reset_ready", in_ready, 1'b1);

    run_op("add",    16'd5,    16'd3,  6'b000010, 2'b00, 16'h0008, 0);
    run_op("sub",    16'd3,    16'd5,  6'b010011, 2'b00, 16'hFFFE, 0);
    run_op("zero",   16'h1234, 16'h55, 6'b101010, 2'b00, 16'h0000, 0);
    run_op("mul",    16'd300,  16'd250, 6'b000000, 2'b11, 16'h24F8, 0);
    run_op("mul_no", 16'd300,  16'd250, 6'b000001, 2'b11, 16'hDB07, 1);
    run_op("sar",    16'h8000, 16'd4,  6'b000000, 2'b10, 16'hF800, 0);
    run_op("shl15",  16'd1,    16'd15, 6'b000000, 2'b01, 16'h8000, 0);
    run_op("shl16",  16'd1,    16'd16, 6'b000000, 2'b01, 16'h0001, 0);
    run_op("shl_ny", 16'd1,    16'd15, 6'b000100, 2'b01, 16'h0001, 0);
    run_op("bp",     16'h00F0, 16'h0F0F, 6'b000000, 2'b00, 16'h0000, 5);
    run_op("b2b",    16'h7FFF, 16'd1,  6'b000010, 2'b00, 16'h8000, 0);

    // Abort a multiply partway through with a one-cycle reset.
    check1("abort_ready", in_ready, 1'b1);
    x = 16'd123; y = 16'd77; ctl = 6'b000000; mode = 2'b11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check1("abort_valid", out_valid, 1'b0);
    check16("abort_out", out, 16'h0000);
    check1("abort_zr", zr, 1'b1);
    check1("abort_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check1("abort_ready_after", in_ready, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check1("abort_no_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    run_op("post_abort", 16'd40, 16'd2, 6'b000010, 2'b00, 16'd42, 0);

    for (int n = 0; n < 40; n++) begin
      rx = 16'($urandom);
      ry = (n % 3 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      rc = 6'($urandom);
      rm = 2'($urandom);
      run_op("rand", rx, ry, rc, rm, model(rx, ry, rc, rm), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_alu_seq.md
Name: hack_alu_seq

Overview:
Multi-cycle, handshaked successor to the Hack CPU combinational ALU, parametrised in data width.
- Keeps the six Hack control bits: zx, nx, zy, ny, f, no.
- Adds a 2-bit mode selecting one of: Hack function, logical shift left, arithmetic shift right, or an iterative shift-add multiply.
- Sits between the CPU decode stage and the D/A register writeback.
- Valid/ready on both sides lets the CPU stall on the multi-cycle multiply.

Parameters:
- D_WIDTH, 16: operand/result width in bits.
- SH_WIDTH, 4: number of low bits of the preprocessed y used as shift amount. Must satisfy 2^SH_WIDTH >= D_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation.
- x  input  D_WIDTH  operand x.
- y  input  D_WIDTH  operand y.
- zx, nx, zy, ny, f, no  input  1 each  Hack ALU control bits.
- mode  input  2  00 Hack, 01 SHL, 10 SAR, 11 MUL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  D_WIDTH  registered result.
- zr  output  1  1 when out == 0.
- ng  output  1  out[D_WIDTH-1].

Behaviour:
- Clock port is clk; reset port is reset. Reset is synchronous and active-high. One clock domain.
- Preprocessing at accept, all modes:
  - vx = zx ? 0 : x, then bitwise inverted if nx.
  - vy = zy ? 0 : y, then bitwise inverted if ny.
- Mode 00: r = f ? (vx + vy) mod 2^D_WIDTH : (vx & vy).
- Mode 01: r = vx << vy[SH_WIDTH-1:0], zero fill; shift amount >= D_WIDTH gives 0. f ignored.
- Mode 10: r = vx arithmetic >> vy[SH_WIDTH-1:0], sign fill; amount >= D_WIDTH gives all copies of vx MSB. f ignored.
- Mode 11: r = low D_WIDTH bits of vx * vy (unsigned shift-add; low bits identical for two's complement). f ignored.
- Final result: out = no ? ~r : r, registered. zr and ng are derived from the registered out.
- State machine: IDLE, MUL, DONE.
  - IDLE: in_ready=1, out_valid=0.
    - Accept on in_valid && in_ready.
    - Modes 00/01/10: result registered in the same edge; go DONE.
    - Mode 11: load acc=0, a=vx, b=vy, cnt=0, latch no; go MUL.
  - MUL: in_ready=0, out_valid=0. Each cycle:
    - if b[0], acc += a (mod 2^D_WIDTH);
    - a <<= 1; b >>= 1; cnt++.
    - After D_WIDTH iterations, register out = no ? ~acc : acc; go DONE.
  - DONE: out_valid=1, in_ready=0. out/zr/ng held stable. On out_ready go IDLE.
- Latency, accept edge = cycle N:
  - modes 00–10: out_valid high in cycle N+1;
  - mode 11: out_valid high in cycle N+D_WIDTH+1.
- Throughput: at most one op per 2 cycles (no accept while in DONE).
- in_valid while not in IDLE: ignored. Inputs are sampled only at accept; later changes have no effect.
- out_ready while out_valid=0: ignored.
- Reset values: state IDLE, out=0, zr=1, ng=0, out_valid=0, internal acc/a/b/cnt=0. in_ready=0 while reset is asserted, 1 in the first cycle after deassertion.
- Reset mid-MUL or in DONE: operation aborted, result discarded, no out_valid pulse.
- Wrap-around: add and multiply truncate silently. There is no carry/overflow output.

Test Plan:
1. Mode 00, controls 000010 (x+y), x=5, y=3, out_ready=1 -> out=8, zr=0, ng=0; out_valid exactly 1 cycle after accept, for one cycle; in_ready back to 1 the next cycle.
2. Mode 00, controls 010011 (x-y), x=3, y=5 -> out=0xFFFE, ng=1. Then controls 101010 (constant 0) -> out=0, zr=1.
3. Mode 11, controls 000000, x=300, y=250 -> out=0x24F8 (75000 mod 65536), out_valid exactly 17 cycles after accept; in_ready=0 and in_valid pulses ignored throughout. Repeat with no=1 -> out=0xDB07.
4. Shifts:
   - mode 10, x=0x8000, y=4 -> 0xF800, ng=1;
   - mode 01, x=1, y=15 -> 0x8000;
   - mode 01, x=1, y=16 (masked amount 0) -> out=1;
   - mode 01, x=1, y=15 with ny=1 (amount 0) -> out=1.
5. Backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid, out, zr, ng stable and no new accept; raise out_ready -> DONE exits, in_ready=1 next cycle, back-to-back op accepted.
6. Assert reset 1 cycle at iteration 5 of a multiply -> next cycle out_valid=0, out=0, zr=1, in_ready=0; after deassert in_ready=1, new mode-00 op completes correctly; aborted multiply never signalled.
